// File: rtl/serial_adder8.sv
// rtl/serial_adder8.sv - bit-serial 8-bit adder, LSB-first, valid/ready on both sides
// Optional subtract path enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] sum,
    output logic       cout,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic       r_carry;
    logic [7:0] r_a_sr;
    logic [7:0] r_b_sr;
    logic [7:0] r_res;
    logic       r_out_valid;
    logic       r_busy;

    logic       w_load;
    logic       w_shift;
    logic       w_sub;
    logic       w_s;
    logic       w_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    logic w_unused_sub;
    assign w_sub        = 1'b0;
    assign w_unused_sub = sub;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)      w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == 3'd7) w_next = S_DONE;
            S_DONE:  if (out_ready)     w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_IDLE) & rst_n;
        w_load   = in_ready & in_valid;
        w_shift  = (r_state == S_SHIFT);
    end

    // Full-adder cell: half-adder pair plus the registered carry feedback.
    assign w_s = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_c = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr  <= 8'h00;
            r_b_sr  <= 8'h00;
            r_res   <= 8'h00;
            r_carry <= 1'b0;
            r_cnt   <= 3'd0;
        end else if (w_load) begin
            r_a_sr  <= a;
            r_b_sr  <= w_sub ? ~b : b;
            r_res   <= 8'h00;
            r_carry <= w_sub;
            r_cnt   <= 3'd0;
        end else if (w_shift) begin
            r_a_sr  <= {1'b0, r_a_sr[7:1]};
            r_b_sr  <= {1'b0, r_b_sr[7:1]};
            r_res   <= {w_s, r_res[7:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + 3'd1;
        end
    end

    // Status flags are registered from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= (w_next == S_DONE);
            r_busy      <= (w_next == S_SHIFT);
        end
    end

    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_res;
    assign cout      = r_carry;

endmodule
